// File: rtl/imm_pack.sv
// -----------------------------------------------------------------------------
// imm_pack -- pipelined immediate encoder (inverse of the immediate extender).
//
// Scatters a 32-bit signed immediate into the I/S/B-type fields of an
// instruction template. It is used on the loader / stimulus path to build
// instruction words before they are written to instruction memory.
//
// Two register stages:
//   S1 holds the template, the selector, the range verdict and the immediate
//      field bits, which are either truncated or clamped.
//   S2 holds the merged instruction word and the range-error flag.
//
// Handshake: a beat moves across an interface on a rising clk edge where
// valid && ready are both high. A producer holds its valid and payload
// steady until that edge. in_ready is combinational, and out_ready may feed
// it directly.
//
// Optional build macro:
//   IMM_PACK_SAT_EN  Out-of-range immediates are clamped to the nearest
//                    representable value. out_range_err is still raised.
//                    When the macro is undefined, the field bits are
//                    truncated.
//
// Parameters:
//   DATA_WIDTH  instruction/immediate width (only 32 is supported)
//   CNT_WIDTH   width of the saturating error counter
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   in_valid       input beat valid
//   in_ready       input beat accepted when in_valid && in_ready
//   in_instr       instruction template (bits in immediate fields ignored)
//   in_imm         signed immediate
//   in_immsrc      00 I-type, 01 S-type, 10 B-type, 11 invalid
//   out_valid      output beat valid
//   out_ready      downstream accepts
//   out_instr      encoded instruction
//   out_range_err  immediate not representable, or in_immsrc == 11
//   cnt_clr        synchronous clear of err_count (wins over increment)
//   err_count      saturating count of errored output handshakes
// -----------------------------------------------------------------------------
module imm_pack #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_instr,
  input  logic [DATA_WIDTH-1:0] in_imm,
  input  logic [1:0]            in_immsrc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic                  out_range_err,
  input  logic                  cnt_clr,
  output logic [CNT_WIDTH-1:0]  err_count
);

  localparam logic [1:0] SRC_I = 2'b00;
  localparam logic [1:0] SRC_S = 2'b01;
  localparam logic [1:0] SRC_B = 2'b10;

  // ---------------------------------------------------------------------------
  // Pipeline flow control
  // ---------------------------------------------------------------------------
  logic s1_valid;
  logic s2_valid;
  logic s1_load;
  logic s2_load;
  logic in_fire;
  logic out_fire;

  // A stage may load when it is empty or when its contents leave this cycle.
  assign s2_load   = !s2_valid || out_ready;
  assign s1_load   = !s1_valid || s2_load;
  assign in_ready  = s1_load;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = s2_valid && out_ready;
  assign out_valid = s2_valid;

  // ---------------------------------------------------------------------------
  // Stage 1 combinational: range check and immediate field selection
  // ---------------------------------------------------------------------------
  // A value fits in 12 signed bits when imm[31:11] are all copies of the sign.
  // It fits in 13 signed bits when imm[31:12] are all copies of the sign.
  logic        hi_is_ok;
  logic        hi_b_ok;
  logic        range_ok;
  logic [12:0] field;

  assign hi_is_ok = (&in_imm[31:11]) || !(|in_imm[31:11]);
  assign hi_b_ok  = (&in_imm[31:12]) || !(|in_imm[31:12]);

  // field holds imm[12:0] as it will be scattered. I/S use bits 11:0.
  // B uses bits 12:1, and bit 0 is always dropped.
  always_comb begin
    range_ok = 1'b0;
    field    = 13'd0;
    unique case (in_immsrc)
      SRC_I, SRC_S: begin
        range_ok = hi_is_ok;
        field    = in_imm[12:0];
`ifdef IMM_PACK_SAT_EN
        // Clamp to [-2048, 2047], expressed in 13 bits.
        if (!hi_is_ok) begin
          field = in_imm[31] ? 13'h1800 : 13'h07FF;
        end
`endif
      end
      SRC_B: begin
        range_ok = hi_b_ok && !in_imm[0];
        field    = {in_imm[12:1], 1'b0};
`ifdef IMM_PACK_SAT_EN
        // Clamp to [-4096, 4094]. Bit 0 is already forced low above.
        if (!hi_b_ok) begin
          field = in_imm[31] ? 13'h1000 : 13'h0FFE;
        end
`endif
      end
      default: begin
        // An invalid selector passes the template through and flags an error.
        range_ok = 1'b0;
        field    = 13'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stage 1 registers
  // ---------------------------------------------------------------------------
  logic [31:0] s1_instr;
  logic [1:0]  s1_src;
  logic        s1_err;
  logic [12:0] s1_field;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_instr <= '0;
      s1_src   <= '0;
      s1_err   <= 1'b0;
      s1_field <= '0;
    end else begin
      // in_ready == s1_load, so S1 refills with whatever is offered.
      if (s1_load) begin
        s1_valid <= in_valid;
      end
      if (in_fire) begin
        s1_instr <= in_instr;
        s1_src   <= in_immsrc;
        s1_err   <= !range_ok;
        s1_field <= field;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 combinational: merge the field into the template
  // ---------------------------------------------------------------------------
  logic [31:0] merged;

  always_comb begin
    merged = s1_instr;
    unique case (s1_src)
      SRC_I: merged = {s1_field[11:0], s1_instr[19:0]};
      SRC_S: merged = {s1_field[11:5], s1_instr[24:12], s1_field[4:0], s1_instr[6:0]};
      SRC_B: merged = {s1_field[12], s1_field[10:5], s1_instr[24:12],
                       s1_field[4:1], s1_field[11], s1_instr[6:0]};
      default: merged = s1_instr;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stage 2 registers (drive the output port directly)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid      <= 1'b0;
      out_instr     <= '0;
      out_range_err <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      // Payload only changes when a real beat arrives. While the stage is
      // stalled, it holds steady.
      if (s1_valid) begin
        out_instr     <= merged;
        out_range_err <= s1_err;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating error counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (cnt_clr) begin
      err_count <= '0;
    end else if (out_fire && out_range_err && (err_count != {CNT_WIDTH{1'b1}})) begin
      err_count <= err_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_imm_pack.sv
// -----------------------------------------------------------------------------
// tb_imm_pack -- self-checking bench for imm_pack.
//
// Two instances share all inputs. u_dut uses a 16-bit counter and u_dut2
// uses a 2-bit counter, so saturation is observable.
//
// Expected beats are computed from the field rules with plain arithmetic and
// pushed on a queue. Every output handshake pops the queue and is compared.
// In-range beats are also decoded back and compared against the original
// immediate.
// -----------------------------------------------------------------------------
module tb_imm_pack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_imm = '0;
  logic [1:0]  in_immsrc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic        out_range_err;
  logic        cnt_clr = 1'b0;
  logic [15:0] err_count;

  logic        in_ready2;
  logic        out_valid2;
  logic [31:0] out_instr2;
  logic        out_range_err2;
  logic [1:0]  err_count2;

  // ---------------------------------------------------------------------------
  // Clock/reset
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  imm_pack #(.DATA_WIDTH(32), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_imm(in_imm), .in_immsrc(in_immsrc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_range_err(out_range_err),
    .cnt_clr(cnt_clr), .err_count(err_count)
  );

  imm_pack #(.DATA_WIDTH(32), .CNT_WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready2),
    .in_instr(in_instr), .in_imm(in_imm), .in_immsrc(in_immsrc),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_instr(out_instr2), .out_range_err(out_range_err2),
    .cnt_clr(cnt_clr), .err_count(err_count2)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [32:0] exp_q[$];
  logic [31:0] imm_q[$];
  logic [1:0]  src_q[$];
  int          exp_cnt;
  int          exp_cnt2;
  int          n_assert;
  int          n_fail;
  bit          hold_chk;
  logic [32:0] hold_val;
  bit          acc;
  int          n_acc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference encoder built from the field placement and range rules.
  function automatic logic [32:0] model(input logic [31:0] t, input logic [31:0] imm,
                                        input logic [1:0] s);
    int          v;
    bit          ok;
    logic [31:0] u;
    logic [31:0] r;
    v = $signed(imm);
    case (s)
      2'd0, 2'd1: ok = (v >= -2048) && (v <= 2047);
      2'd2:       ok = (v >= -4096) && (v <= 4095) && (imm[0] == 1'b0);
      default:    ok = 1'b0;
    endcase
`ifdef IMM_PACK_SAT_EN
    if (!ok && s != 2'd3) begin
      if (s == 2'd2) begin
        if (v > 4094)       v = 4094;
        else if (v < -4096) v = -4096;
        else                v = v & ~1;
      end else begin
        if (v > 2047)       v = 2047;
        else if (v < -2048) v = -2048;
      end
    end
`endif
    u = v;
    case (s)
      2'd0: r = (t & 32'h000F_FFFF) | ((u & 32'hFFF) << 20);
      2'd1: r = (t & 32'h01FF_F07F) | (((u >> 5) & 32'h7F) << 25) | ((u & 32'h1F) << 7);
      2'd2: r = (t & 32'h01FF_F07F) | (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25)
               | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 32'h1) << 7);
      default: r = t;
    endcase
    return {!ok, r};
  endfunction

  // Immediate extender, used to decode in-range beats back to the immediate.
  function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] s);
    case (s)
      2'd0:    return {{20{w[31]}}, w[31:20]};
      2'd1:    return {{20{w[31]}}, w[31:25], w[11:7]};
      default: return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: one clock cycle. Inputs are set at the negedge before the call.
  // The task samples, scores the handshakes at the coming posedge, and
  // returns at the next negedge.
  // ---------------------------------------------------------------------------
  task automatic cycle(output bit accepted);
    logic [32:0] e;
    logic [31:0] im;
    logic [1:0]  sr;
    bit          of;
    bit          err_hs;
    #1;
    accepted = in_valid && in_ready;
    of       = out_valid && out_ready;
    err_hs   = 1'b0;
    check("in_ready", in_ready, (exp_q.size() < 2) || out_ready);
    if (hold_chk) begin
      check("hold_valid", out_valid, 1'b1);
      check("hold_data", {out_range_err, out_instr}, hold_val);
    end
    hold_chk = out_valid && !out_ready;
    hold_val = {out_range_err, out_instr};
    if (of) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", out_valid, 1'b0);
      end else begin
        e  = exp_q.pop_front();
        im = imm_q.pop_front();
        sr = src_q.pop_front();
        err_hs = e[32];
        check("out_instr", out_instr, e[31:0]);
        check("out_err", out_range_err, e[32]);
        if (!e[32]) check("round_trip", extend(out_instr, sr), im);
      end
    end
    if (cnt_clr) begin
      exp_cnt  = 0;
      exp_cnt2 = 0;
    end else if (err_hs) begin
      if (exp_cnt < 65535) exp_cnt++;
      if (exp_cnt2 < 3) exp_cnt2++;
    end
    if (accepted) begin
      exp_q.push_back(model(in_instr, in_imm, in_immsrc));
      imm_q.push_back(in_imm);
      src_q.push_back(in_immsrc);
      n_acc++;
    end
    @(posedge clk);
    @(negedge clk);
    check("err_count", err_count, exp_cnt);
    check("err_count2", err_count2, exp_cnt2);
  endtask

  task automatic send(input logic [31:0] t, input logic [31:0] imm, input logic [1:0] s);
    bit a;
    in_valid  = 1'b1;
    in_instr  = t;
    in_imm    = imm;
    in_immsrc = s;
    a = 1'b0;
    for (int i = 0; i < 50 && !a; i++) cycle(a);
    if (!a) check("send_timeout", a, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit a;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) cycle(a);
    check("drain_empty", exp_q.size(), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed and random stimulus
  // ---------------------------------------------------------------------------
  logic [31:0] bp_imm[6];
  int          bnd[13];
  int          idx;
  bit          pend;

  initial begin
    bnd = '{2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096, -4097, -4095, 0, 1, -1};
    n_assert = 0; n_fail = 0; exp_cnt = 0; exp_cnt2 = 0; hold_chk = 0; n_acc = 0;

    // Reset
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_err", out_range_err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_err_count", err_count, 16'h0);
    @(negedge clk);

    // I-type with a 2-cycle latency check
    in_valid = 1'b1; in_instr = 32'h0000_0013; in_imm = -32'sd5; in_immsrc = 2'd0;
    cycle(acc);
    check("i_accept", acc, 1'b1);
    in_valid = 1'b0;
    check("i_lat_n1", out_valid, 1'b0);
    cycle(acc);
    check("i_lat_n2", out_valid, 1'b1);
    check("i_instr", out_instr, 32'hFFB0_0013);
    check("i_err", out_range_err, 1'b0);
    drain();

    // S then B back-to-back at full rate
    in_valid = 1'b1; in_instr = 32'h0000_2023; in_imm = 32'd20; in_immsrc = 2'd1;
    cycle(acc);
    in_instr = 32'h0000_0063; in_imm = -32'sd8; in_immsrc = 2'd2;
    cycle(acc);
    check("b_accept", acc, 1'b1);
    in_valid = 1'b0;
    check("s_instr", out_instr, 32'h0000_2A23);
    cycle(acc);
    check("b_valid", out_valid, 1'b1);
    check("b_instr", out_instr, 32'hFE00_0CE3);
    check("b_err", out_range_err, 1'b0);
    drain();

    // Range error, I-type 3000
    cnt_clr = 1'b1; cycle(acc); cnt_clr = 1'b0;
    send(32'h0000_0013, 32'd3000, 2'd0);
    cycle(acc);
`ifdef IMM_PACK_SAT_EN
    check("rng_instr", out_instr, 32'h7FF0_0013);
`else
    check("rng_instr", out_instr, 32'hBB80_0013);
`endif
    check("rng_err", out_range_err, 1'b1);
    drain();
    check("rng_cnt", err_count, 16'd1);
    send(32'h1234_5678, 32'd7, 2'd3);
    drain();

    // Backpressure: 6 beats, out_ready low for 4 cycles
    for (int i = 0; i < 6; i++) bp_imm[i] = 32'(i * 37 - 90);
    idx = 0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h0000_0013; in_immsrc = 2'd0; in_imm = bp_imm[0];
    for (int c = 0; c < 4; c++) begin
      cycle(acc);
      if (acc) begin idx++; in_imm = bp_imm[idx]; end
    end
    check("bp_accepts", idx, 2);
    #1 check("bp_in_ready", in_ready, 1'b0);
    @(negedge clk);
    out_ready = 1'b1;
    for (int c = 0; c < 50 && idx < 6; c++) begin
      cycle(acc);
      if (acc) begin idx++; if (idx < 6) in_imm = bp_imm[idx]; end
    end
    in_valid = 1'b0;
    check("bp_all_sent", idx, 6);
    drain();

    // Counter: 3 errors, then clear on the same cycle as the 4th
    cnt_clr = 1'b1; cycle(acc); cnt_clr = 1'b0;
    for (int i = 0; i < 3; i++) send(32'hA5A5_0000 + 32'(i), 32'd0, 2'd3);
    drain();
    check("cnt_three", err_count, 16'd3);
    send(32'h0000_0013, 32'd5000, 2'd0);
    for (int i = 0; i < 20 && !out_valid; i++) cycle(acc);
    cnt_clr = 1'b1;
    cycle(acc);
    cnt_clr = 1'b0;
    check("cnt_clr_win", err_count, 16'd0);
    // Saturation of the 2-bit counter
    for (int i = 0; i < 5; i++) send(32'h0000_0063, 32'd1, 2'd2);
    drain();
    check("cnt_five", err_count, 16'd5);
    check("cnt2_sat", err_count2, 2'd3);

    // Reset mid-stream with both stages full
    out_ready = 1'b0;
    send(32'h0000_0013, 32'd1, 2'd0);
    send(32'h0000_0013, 32'd2, 2'd0);
    #1 check("mid_full", in_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_async_valid", out_valid, 1'b0);
    check("mid_cnt", err_count, 16'd0);
    exp_q.delete(); imm_q.delete(); src_q.delete();
    exp_cnt = 0; exp_cnt2 = 0; hold_chk = 0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    cycle(acc);
    check("mid_no_stale1", out_valid, 1'b0);
    cycle(acc);
    check("mid_no_stale2", out_valid, 1'b0);
    in_valid = 1'b1; in_instr = 32'h0000_2023; in_imm = -32'sd1; in_immsrc = 2'd1;
    cycle(acc);
    in_valid = 1'b0;
    check("mid_lat1", out_valid, 1'b0);
    cycle(acc);
    check("mid_lat2", out_valid, 1'b1);
    check("mid_instr", out_instr, 32'hFE00_2FA3);
    drain();

    // Random traffic against the model
    pend = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!pend) begin
        in_instr  = $urandom;
        in_immsrc = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
          0: in_imm = 32'($signed($urandom_range(0, 10000)) - 5000);
          1: in_imm = 32'(bnd[$urandom_range(0, 12)]);
          2: in_imm = $urandom;
          default: in_imm = 32'(($signed($urandom_range(0, 8190)) - 4096) & ~1);
        endcase
        pend = 1'b1;
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cnt_clr   = ($urandom_range(0, 29) == 0);
      cycle(acc);
      if (acc) pend = 1'b0;
    end
    in_valid = 1'b0; cnt_clr = 1'b0; out_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
